// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction/data main-memory arbiter.
// Holds the FSM state encoding, requester identifiers and default widths.
package imem_arb_pkg;

  // Default line address width (64 main-memory lines).
  localparam int unsigned DefAddrW = 6;
  // Default line width (4 x 32-bit words).
  localparam int unsigned DefLineW = 128;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Requester identifiers; also the bit position of each requester in req/grant vectors.
  typedef enum logic {
    ReqI = 1'b0,
    ReqD = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-input request picker producing a one-hot grant.
// Default build: round robin, the requester not granted last wins a tie.
// With IMEM_ARB_IFETCH_PRIO_EN defined: fixed priority, I always wins a tie.
module arb_rr2
  import imem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last_grant,
  output logic [1:0] grant
);

`ifdef IMEM_ARB_IFETCH_PRIO_EN
  // History is irrelevant under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority: I first, D only when I is idle.
  always_comb begin
    grant = 2'b00;
    if (req[ReqI]) begin
      grant[ReqI] = 1'b1;
    end else if (req[ReqD]) begin
      grant[ReqD] = 1'b1;
    end
  end
`else
  // Round robin: a lone request wins outright, a tie goes to the other side of last_grant.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == ReqI) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Sequencer and two-way arbiter in front of the single-port main-memory macro.
// Requester I (I-cache refill, read only) and requester D (data line port, read or
// masked write) share the memory; each request gets exactly one response pulse.
// Optional feature macro: IMEM_ARB_IFETCH_PRIO_EN (fixed priority for I instead of
// round robin).
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned LINE_W  = DefLineW,
  parameter int unsigned MEM_LAT = 1  // legal range 1..4
) (
  input  logic                 clk,
  input  logic                 reset,
  // I-cache refill port
  input  logic                 i_req,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [LINE_W-1:0]    i_rdata,
  output logic                 i_valid,
  // Data-side line port
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [LINE_W-1:0]    d_wdata,
  input  logic [LINE_W/32-1:0] d_wmask,
  output logic [LINE_W-1:0]    d_rdata,
  output logic                 d_valid,
  // Memory macro
  output logic                 mem_en,
  output logic [LINE_W/32-1:0] mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_W-1:0]    mem_wdata,
  input  logic [LINE_W-1:0]    mem_rdata,
  // Status
  output logic                 busy
);

  // Two bits cover a wait count of up to MEM_LAT-1 = 3.
  localparam int unsigned CntW = 2;
  localparam logic [CntW-1:0] WaitLoad = CntW'(MEM_LAT - 1);

  arb_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  req_id_e         last_grant_q;  // also identifies the owner of the transaction in flight
  logic            we_q;
  logic [1:0]      grant;

  arb_rr2 u_arb (
    .req        ({d_req, i_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Transaction FSM; every output is a register so the macro sees clean edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= ReqD;  // I wins the first tie
      we_q         <= 1'b0;
      i_valid      <= 1'b0;
      d_valid      <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      // Single-cycle strobes; address and write data deliberately hold.
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= '0;

      unique case (state_q)
        StIdle: begin
          if (grant != 2'b00) begin
            state_q <= StIssue;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            if (grant[ReqD]) begin
              last_grant_q <= ReqD;
              we_q         <= d_we;
              mem_addr     <= d_addr;
              mem_wdata    <= d_wdata;
              mem_we       <= d_we ? d_wmask : '0;
            end else begin
              // I refills are reads; mem_wdata keeps its previous value.
              last_grant_q <= ReqI;
              we_q         <= 1'b0;
              mem_addr     <= i_addr;
            end
          end
        end

        StIssue: begin
          state_q <= StWait;
          cnt_q   <= WaitLoad;
        end

        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
            if (last_grant_q == ReqI) begin
              i_valid <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_valid <= 1'b1;
              // Writes acknowledge without disturbing the last read line.
              if (!we_q) begin
                d_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        StResp: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed self-checking bench for imem_arbiter.
// dut1 runs with MEM_LAT=1, dut3 with MEM_LAT=3; each has its own memory model.
module tb_imem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT=1 instance signals
  logic         i_req, d_req, d_we;
  logic [5:0]   i_addr, d_addr, mem_addr;
  logic [127:0] d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0]   d_wmask, mem_we;
  logic         i_valid, d_valid, mem_en, busy;

  // MEM_LAT=3 instance signals
  logic         t3_i_req, t3_d_req, t3_d_we;
  logic [5:0]   t3_i_addr, t3_d_addr, t3_mem_addr;
  logic [127:0] t3_d_wdata, t3_i_rdata, t3_d_rdata, t3_mem_wdata, t3_mem_rdata;
  logic [3:0]   t3_d_wmask, t3_mem_we;
  logic         t3_i_valid, t3_d_valid, t3_mem_en, t3_busy;

  imem_arbiter #(.ADDR_W(6), .LINE_W(128), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  imem_arbiter #(.ADDR_W(6), .LINE_W(128), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .i_req(t3_i_req), .i_addr(t3_i_addr), .i_rdata(t3_i_rdata), .i_valid(t3_i_valid),
    .d_req(t3_d_req), .d_we(t3_d_we), .d_addr(t3_d_addr), .d_wdata(t3_d_wdata),
    .d_wmask(t3_d_wmask), .d_rdata(t3_d_rdata), .d_valid(t3_d_valid),
    .mem_en(t3_mem_en), .mem_we(t3_mem_we), .mem_addr(t3_mem_addr),
    .mem_wdata(t3_mem_wdata), .mem_rdata(t3_mem_rdata), .busy(t3_busy)
  );

  // Power-on contents: line 5 is all A5, other lines encode their address and word index.
  function automatic logic [127:0] init_line(input logic [5:0] a);
    logic [127:0] l;
    l = '0;
    if (a == 6'd5) begin
      l = {16{8'hA5}};
    end else begin
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = {8'h5A, 2'b00, a, 8'(w), 8'hC3};
    end
    return l;
  endfunction

  // Memory model, latency 1: line appears on the cycle after the enable edge.
  logic [127:0] mem1 [64];
  logic [127:0] p1;
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 64; k++) mem1[k] <= init_line(6'(k));
      p1 <= '0;
    end else begin
      if (mem_en) begin
        for (int w = 0; w < 4; w++) begin
          if (mem_we[w]) mem1[mem_addr][w*32 +: 32] <= mem_wdata[w*32 +: 32];
        end
      end
      p1 <= mem_en ? mem1[mem_addr] : '0;
    end
  end
  assign mem_rdata = p1;

  // Memory model, latency 3: data is zero except in the one correct capture cycle.
  logic [127:0] mem3 [64];
  logic [127:0] p3 [3];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 64; k++) mem3[k] <= init_line(6'(k));
      for (int s = 0; s < 3; s++) p3[s] <= '0;
    end else begin
      if (t3_mem_en) begin
        for (int w = 0; w < 4; w++) begin
          if (t3_mem_we[w]) mem3[t3_mem_addr][w*32 +: 32] <= t3_mem_wdata[w*32 +: 32];
        end
      end
      p3[0] <= t3_mem_en ? mem3[t3_mem_addr] : '0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end
  assign t3_mem_rdata = p3[2];

  // Lock-step monitor: every enable must be matched by one response unless reset intervenes.
  int pend = 0;
  int cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) pend <= 0;
    else pend <= pend + (mem_en ? 1 : 0) - ((i_valid || d_valid) ? 1 : 0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise the requested sides, wait for a response, drop the winner and step one cycle.
  task automatic serve(input logic want_i, input logic want_d,
                       output logic won_d, output int lat, output int en_cnt,
                       output int we_cnt, output int en_at,
                       output logic [3:0] we_seen, output logic [5:0] addr_seen);
    logic done;
    done = 1'b0; won_d = 1'b0; lat = 0; en_cnt = 0; we_cnt = 0; en_at = 0;
    we_seen = '0; addr_seen = '0;
    if (want_i) i_req = 1'b1;
    if (want_d) d_req = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_en) begin
        en_cnt++;
        en_at = cyc;
        we_seen = mem_we;
        addr_seen = mem_addr;
      end
      if (mem_we != 4'b0000) we_cnt++;
      if (i_valid || d_valid) begin
        done = 1'b1;
        won_d = d_valid;
        check("one_valid", 128'(i_valid & d_valid), 128'(0));
      end
    end
    check("no_timeout", 128'(done), 128'(1));
    if (won_d) d_req = 1'b0;
    else i_req = 1'b0;
    @(posedge clk); #1;
    check("valid_drop", 128'(i_valid | d_valid), 128'(0));
  endtask

  logic         won;
  int           lat, enc, wec, ena;
  logic [3:0]   wes;
  logic [5:0]   ads;
  logic [127:0] exp_line;
  logic [2:0]   order, exp_order;
  int           at [3];
  logic         seen;

  initial begin
    i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    t3_i_req = 0; t3_d_req = 0; t3_d_we = 0; t3_i_addr = '0; t3_d_addr = '0;
    t3_d_wdata = '0; t3_d_wmask = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mem_en", 128'(mem_en), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_valids", 128'({i_valid, d_valid}), 128'(0));
    check("rst_i_rdata", i_rdata, 128'(0));
    check("rst_d_rdata", d_rdata, 128'(0));

    // Single I read of line 5
    i_addr = 6'h05;
    serve(1'b1, 1'b0, won, lat, enc, wec, ena, wes, ads);
    check("i_lat", 128'(lat), 128'(3));
    check("i_en_cycles", 128'(enc), 128'(1));
    check("i_mem_addr", 128'(ads), 128'(5));
    check("i_mem_we", 128'(wes), 128'(0));
    check("i_winner", 128'(won), 128'(0));
    check("i_rdata", i_rdata, {16{8'hA5}});
    check("i_idle_after", 128'(busy), 128'(0));

    // Masked D write of word 2 of line 10
    d_addr = 6'h0A; d_we = 1'b1; d_wmask = 4'b0100;
    d_wdata = {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333};
    serve(1'b0, 1'b1, won, lat, enc, wec, ena, wes, ads);
    check("w_lat", 128'(lat), 128'(3));
    check("w_mem_we", 128'(wes), 128'(4'b0100));
    check("w_we_cycles", 128'(wec), 128'(1));
    check("w_winner", 128'(won), 128'(1));
    check("w_d_rdata_kept", d_rdata, 128'(0));

    // D read back of line 10
    d_we = 1'b0; d_wmask = 4'b0000; d_wdata = '0;
    serve(1'b0, 1'b1, won, lat, enc, wec, ena, wes, ads);
    exp_line = init_line(6'h0A);
    exp_line[95:64] = 32'hDEADBEEF;
    check("r_lat", 128'(lat), 128'(3));
    check("r_mem_we", 128'(wes), 128'(0));
    check("r_d_rdata", d_rdata, exp_line);

    // Simultaneous requests, both sides keep re-requesting
    i_addr = 6'h05; d_addr = 6'h0A; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      serve(1'b0, 1'b0, won, lat, enc, wec, ena, wes, ads);
      order[r] = won;
      at[r] = ena;
      if (won) d_req = 1'b1;
      else i_req = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0;
`ifdef IMEM_ARB_IFETCH_PRIO_EN
    exp_order = 3'b000;
`else
    exp_order = 3'b010;
`endif
    check("arb_order", 128'(order), 128'(exp_order));
    check("b2b_gap_1", 128'(at[1] - at[0]), 128'(4));
    check("b2b_gap_2", 128'(at[2] - at[1]), 128'(4));
    @(posedge clk); #1;
    check("arb_idle_after", 128'(busy), 128'(0));

    // MEM_LAT=3 single I read
    t3_i_addr = 6'h05;
    t3_i_req = 1'b1;
    lat = 0; enc = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      lat++;
      if (t3_mem_en) enc++;
      if (t3_i_valid) seen = 1'b1;
    end
    t3_i_req = 1'b0;
    check("l3_valid_seen", 128'(seen), 128'(1));
    check("l3_lat", 128'(lat), 128'(5));
    check("l3_en_cycles", 128'(enc), 128'(1));
    check("l3_i_rdata", t3_i_rdata, {16{8'hA5}});

    // Reset while a write sits in ISSUE: strobe must drop right after the reset edge
    d_addr = 6'h0C; d_we = 1'b1; d_wmask = 4'b1111; d_wdata = {128{1'b1}};
    d_req = 1'b1;
    @(posedge clk); #1;
    check("wr_issue_we", 128'(mem_we), 128'(4'b1111));
    reset = 1'b1;
    @(posedge clk); #1;
    check("wr_rst_we", 128'(mem_we), 128'(0));
    check("wr_rst_en", 128'(mem_en), 128'(0));
    check("wr_rst_busy", 128'(busy), 128'(0));
    reset = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wmask = '0; d_wdata = '0;

    // Reset during WAIT of a D read
    d_addr = 6'h0A;
    d_req = 1'b1;
    @(posedge clk); #1;  // ISSUE
    @(posedge clk); #1;  // WAIT
    reset = 1'b1;
    @(posedge clk); #1;
    check("rw_d_valid", 128'(d_valid), 128'(0));
    check("rw_busy", 128'(busy), 128'(0));
    check("rw_mem_en", 128'(mem_en), 128'(0));
    reset = 1'b0; d_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (d_valid) seen = 1'b1;
    end
    check("rw_no_late_valid", 128'(seen), 128'(0));

    // Fresh requests after reset complete normally
    i_addr = 6'h05;
    serve(1'b1, 1'b0, won, lat, enc, wec, ena, wes, ads);
    check("post_rst_i_lat", 128'(lat), 128'(3));
    check("post_rst_i_rdata", i_rdata, {16{8'hA5}});
    d_addr = 6'h0A;
    serve(1'b0, 1'b1, won, lat, enc, wec, ena, wes, ads);
    check("post_rst_d_rdata", d_rdata, init_line(6'h0A));

    // Requester keeps req high a cycle past valid: a second transaction starts from IDLE
    i_addr = 6'h07;
    serve(1'b1, 1'b0, won, lat, enc, wec, ena, wes, ads);
    check("viol_first_rdata", i_rdata, init_line(6'h07));
    i_req = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    check("viol_second_busy", 128'(busy), 128'(1));
    check("viol_second_en", 128'(mem_en), 128'(1));
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (i_valid) seen = 1'b1;
    end
    check("viol_second_valid", 128'(seen), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    check("lockstep", 128'(pend), 128'(0));
    check("final_idle", 128'(busy), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Sequences the single-port instruction/data main memory (synchronous block RAM, 128-bit lines, fixed read latency) and shares it between two requesters.
- Requester I is the I-cache line refill path (read only). Requester D is the data-side line port (read or masked write).
- Sits between the cache controllers and the memory macro. It owns the macro's enable, write-enable and address.
- Serialises accesses and returns one response pulse per request.

Parameters:
- ADDR_W, 6, line address width (64 main-memory lines).
- LINE_W, 128, line width in bits (4 x 32-bit words).
- MEM_LAT, 1, memory read latency in cycles, from enable edge to rdata valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  I refill request; held high until i_valid.
- i_addr  in  ADDR_W  I line address; stable while i_req=1.
- i_rdata  out  LINE_W  I returned line; held until the next I response.
- i_valid  out  1  one-cycle I response pulse.
- d_req  in  1  D request; held high until d_valid.
- d_we  in  1  1 = write, 0 = read; stable while d_req=1.
- d_addr  in  ADDR_W  D line address.
- d_wdata  in  LINE_W  D write data.
- d_wmask  in  LINE_W/32  per-word write enable.
- d_rdata  out  LINE_W  D read line; held until the next D read response.
- d_valid  out  1  one-cycle D response pulse (read data or write acknowledge).
- mem_en  out  1  memory enable.
- mem_we  out  LINE_W/32  memory per-word write enable.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE: if any request is high, choose the winner, latch its address, we, wdata and mask, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1 and mem_addr = latched address.
  - mem_we = latched mask if the winner is D and d_we=1, else 0.
  - mem_wdata = latched wdata.
- WAIT (MEM_LAT cycles): counter runs from MEM_LAT-1 down to 0. On the final WAIT edge, mem_rdata is captured into the winner's rdata register (reads only).
- RESP (1 cycle): the winner's valid=1, then go to IDLE.
- Latency: a request first seen in IDLE at edge N produces valid in cycle N+MEM_LAT+2 (3 cycles for MEM_LAT=1).
- Back-to-back transactions are MEM_LAT+3 cycles apart.
- Handshake:
  - The requester drops req on the edge at which it sees valid. The arbiter re-samples requests only in IDLE, the cycle after RESP.
  - Inputs are ignored outside IDLE.
- Arbitration: round robin over 2 requesters.
  - last_grant records the last winner.
  - On simultaneous requests, the requester that was not last granted wins.
  - A lone request always wins immediately.
- Write transactions: d_rdata is unchanged; d_valid still pulses in RESP.
- Outputs outside ISSUE: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- Reset values: state=IDLE, i_valid=d_valid=0, mem_en=0, mem_we=0, busy=0, mem_addr=0, mem_wdata=0, i_rdata=d_rdata=0, wait counter=0, last_grant=D (so I wins the first tie).
- Reset mid-operation: the transaction is abandoned, no valid pulse is issued, and a write in ISSUE is not asserted after the reset edge. Requesters must re-request.
- An address change while req=1 is a protocol violation; the arbiter uses the value latched in IDLE.

Optional Feature:
- Macro: IMEM_ARB_IFETCH_PRIO_EN.
- Defined: fixed priority, I always wins a tie and last_grant is unused. This bounds fetch-stall latency.
- Undefined: round-robin arbitration as described above.

Decomposition:
- Shared package/include imem_arb_pkg holds:
  - state encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - requester IDs (REQ_I=0, REQ_D=1);
  - default widths (ADDR_W, LINE_W).
- One natural sub-module, arb_rr2: 2-input round-robin picker. It takes req[1:0] and last_grant and produces a one-hot grant; under the macro it becomes fixed priority.

Test Plan:
- i_req=1, i_addr=6'h05, mem line 5 = 128'hA5..A5, MEM_LAT=1 -> mem_en for exactly 1 cycle with mem_addr=5, i_valid 3 cycles after request, i_rdata=128'hA5..A5, d_valid stays 0.
- d_req=1, d_we=1, d_addr=6'h0A, d_wmask=4'b0100, d_wdata word2=32'hDEADBEEF -> mem_we=4'b0100 in ISSUE only, d_valid after 3 cycles; a following D read of line 10 returns word2=32'hDEADBEEF with other words unchanged.
- i_req and d_req rise together after reset, 3 rounds -> grant order I, D, I. With IMEM_ARB_IFETCH_PRIO_EN: I, I, I while I keeps re-requesting.
- MEM_LAT=3, single I read -> i_valid exactly 5 cycles after request; rdata is captured from the third post-enable cycle.
- Assert reset during WAIT of a D read -> no d_valid, busy=0 and mem_en=0 on the next cycle; a fresh request then completes normally.
- Requester holds req high one cycle past valid (violation) -> a second transaction starts from IDLE; the bench flags it. Lock-step check: no mem_en without a later valid absent reset.
